// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline encodings used by the hazard/forwarding logic.
package riscv_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] RES_IMM  = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // M has priority over W; x0 is never a forwarding source.
  function automatic fwd_sel_t fwd_sel(input logic [4:0] rs,
                                       input logic       regw_m,
                                       input logic [4:0] rd_m,
                                       input logic       regw_w,
                                       input logic [4:0] rd_w);
    if (regw_m && (rd_m != REG_ZERO) && (rd_m == rs))
      return FWD_MEM;
    else if (regw_w && (rd_w != REG_ZERO) && (rd_w == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_track_stage.sv
// One shadow pipeline stage: holds on stall, loads a zeroed bubble on flush.
module hazard_track_stage #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q;
  logic [W-1:0] stage_d;

  always_comb begin
    stage_d = stage_q;
    if (!stall_i) stage_d = flush_i ? '0 : d_i;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) stage_q <= '0;
    else           stage_q <= stage_d;
  end

  assign q_o = stage_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard/forwarding controller for the 5-stage RV32I pipeline, tracking its
// own shadow copy of E/M/W register addresses and write-enables.
module hazard_unit
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rdD,
  input  logic             reg_writeD,
  input  logic [1:0]       res_srcD,
  input  logic             pc_srcE,
  input  logic             dmem_busy_i,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushW,
  output logic [CNT_W-1:0] load_use_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [4:0]  rs1E, rs2E, rdE, rdM, rdW;
  logic        regwE, loadE, regwM, regwW;
  logic [16:0] e_d, e_q;
  logic [5:0]  m_d, m_q, w_d, w_q;

  logic        busy;
  logic        lw_stall;
  logic        take;
  logic        stall_fd, stall_em, flush_d, flush_e, flush_w;
  fwd_sel_t    fwd_a, fwd_b;

  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;

  // Memory wait overrides everything; load-use and taken control wait it out.
  assign busy     = dmem_busy_i;
  assign lw_stall = !busy && loadE && (rdE != REG_ZERO) &&
                    ((rdE == rs1D) || (rdE == rs2D));
  assign take     = !busy && pc_srcE;

  assign stall_fd = busy || lw_stall;
  assign stall_em = busy;
  assign flush_d  = take;
  assign flush_e  = lw_stall || take;
  assign flush_w  = busy;

  assign e_d = {rs1D, rs2D, rdD, reg_writeD, (res_srcD == RES_LOAD)};
  assign m_d = {rdE, regwE};
  assign w_d = {rdM, regwM};

  hazard_track_stage #(.W(17)) u_stage_e (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .stall_i  (stall_em),
    .flush_i  (flush_e),
    .d_i      (e_d),
    .q_o      (e_q)
  );

  hazard_track_stage #(.W(6)) u_stage_m (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .stall_i  (stall_em),
    .flush_i  (1'b0),
    .d_i      (m_d),
    .q_o      (m_q)
  );

  hazard_track_stage #(.W(6)) u_stage_w (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .stall_i  (1'b0),
    .flush_i  (flush_w),
    .d_i      (w_d),
    .q_o      (w_q)
  );

  assign {rs1E, rs2E, rdE, regwE, loadE} = e_q;
  assign {rdM, regwM}                    = m_q;
  assign {rdW, regwW}                    = w_q;

  assign fwd_a = fwd_sel(rs1E, regwM, rdM, regwW, rdW);
  assign fwd_b = fwd_sel(rs2E, regwM, rdM, regwW, rdW);

  always_comb begin
    lu_cnt_d = lu_cnt_q;
    fl_cnt_d = fl_cnt_q;
    if (lw_stall && (lu_cnt_q != '1)) lu_cnt_d = lu_cnt_q + CNT_W'(1);
    if (take && (fl_cnt_q != '1))     fl_cnt_d = fl_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  // Inputs can still be active during reset, so controls are gated here.
  assign forwardAE = reset_ni ? fwd_a : FWD_RF;
  assign forwardBE = reset_ni ? fwd_b : FWD_RF;
  assign stallF    = reset_ni && stall_fd;
  assign stallD    = reset_ni && stall_fd;
  assign stallE    = reset_ni && stall_em;
  assign stallM    = reset_ni && stall_em;
  assign flushD    = reset_ni && flush_d;
  assign flushE    = reset_ni && flush_e;
  assign flushW    = reset_ni && flush_w;

  assign load_use_cnt_o = lu_cnt_q;
  assign flush_cnt_o    = fl_cnt_q;

endmodule
